// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// counter-width helper used to size the digit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of one bit, so a single-step adder still
    // gets a real counter register.
    function automatic int clog2_min1(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple-carry slice. Besides the sum and carry out
// it exposes the carry into its top bit, which the parent needs to compute
// signed overflow on the final digit.
module adder_slice
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    // Ripple a chain of full-adder cells from bit 0 upward.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock through one
// ripple slice with a registered carry between digits. Subtraction is done
// as a + ~b + 1, so carry_out = 1 means "no borrow" in that mode.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = clog2_min1(STEPS);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH-1:0]        a_reg;
    logic [WIDTH-1:0]        b_reg;
    logic                    carry_reg;
    logic [CNT_W-1:0]        count;
    logic [DIGIT-1:0]        slice_s;
    logic                    slice_cout;
    logic                    slice_cmsb;
    logic                    accept;
    logic                    last_step;
    logic [WIDTH+DIGIT-1:0]  sum_cat;
    logic [WIDTH-1:0]        sum_shifted;

    // A new request is only taken when no operation is in flight; during
    // the done cycle this gives back-to-back operation.
    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (count == CNT_W'(STEPS - 1));

    // Slice result enters the sum register from the MSB side.
    assign sum_cat     = {slice_s, sum};
    assign sum_shifted = sum_cat[WIDTH+DIGIT-1:DIGIT];

    adder_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a     (a_reg[DIGIT-1:0]),
        .b     (b_reg[DIGIT-1:0]),
        .cin   (carry_reg),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE, or DONE -> RUN on start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand shift registers, digit carry, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : carry_in;
            count     <= '0;
        end else if (state == RUN) begin
            a_reg     <= a_reg >> DIGIT;
            b_reg     <= b_reg >> DIGIT;
            carry_reg <= slice_cout;
            count     <= count + CNT_W'(1);
            sum       <= sum_shifted;
            if (last_step) begin
                carry_out <= slice_cout;
                overflow  <= slice_cmsb ^ slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Two instances are exercised: an
// 8-bit bit-serial one and a 16-bit one with 4-bit digits. Expected results
// come from a plain integer model and are queued when a start is driven,
// then popped when the matching done pulse appears.
module tb_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start8;
    logic        sub8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    logic        start16;
    logic        sub16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;
    logic        ovf16;

    exp_t exp8_q[$];
    exp_t exp16_q[$];

    int total;
    int bad;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .sub       (sub8),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (cout8),
        .overflow  (ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start16),
        .sub       (sub16),
        .a         (a16),
        .b         (b16),
        .carry_in  (cin16),
        .busy      (busy16),
        .done      (done16),
        .sum       (sum16),
        .carry_out (cout16),
        .overflow  (ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Whole-word reference: carry out is bit w of the full sum, carry into
    // the MSB comes from adding only the low w-1 bits.
    function automatic exp_t model(input int w, input logic [15:0] av,
                                   input logic [15:0] bv, input logic s,
                                   input logic c);
        logic [31:0] mask;
        logic [31:0] lmask;
        logic [31:0] bb;
        logic [31:0] cc;
        logic [31:0] full;
        logic [31:0] low;
        exp_t        e;
        mask  = (32'd1 << w) - 32'd1;
        lmask = mask >> 1;
        bb    = s ? ((~{16'h0, bv}) & mask) : {16'h0, bv};
        cc    = s ? 32'd1 : {31'd0, c};
        full  = {16'h0, av} + bb + cc;
        low   = ({16'h0, av} & lmask) + (bb & lmask) + cc;
        e.sum  = full[15:0] & mask[15:0];
        e.cout = full[w];
        e.ovf  = low[w-1] ^ full[w];
        return e;
    endfunction

    task automatic drive_start8(input logic [7:0] av, input logic [7:0] bv,
                                input logic s, input logic c);
        a8 = av; b8 = bv; sub8 = s; cin8 = c; start8 = 1'b1;
        exp8_q.push_back(model(8, {8'h0, av}, {8'h0, bv}, s, c));
    endtask

    task automatic drive_start16(input logic [15:0] av, input logic [15:0] bv,
                                 input logic s, input logic c);
        a16 = av; b16 = bv; sub16 = s; cin16 = c; start16 = 1'b1;
        exp16_q.push_back(model(16, av, bv, s, c));
    endtask

    // Scramble operand inputs after the start edge; they must not matter.
    task automatic scramble8();
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic scramble16();
        a16 = 16'($urandom); b16 = 16'($urandom);
        sub16 = 1'($urandom); cin16 = 1'($urandom);
    endtask

    // Step negedges until done (bounded), counting busy cycles on the way.
    task automatic wait_done8(output int busy_cnt, output int lat, output bit seen);
        busy_cnt = 0; lat = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            if (busy8) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done16(output int busy_cnt, output int lat, output bit seen);
        busy_cnt = 0; lat = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done16) begin
                seen = 1;
                break;
            end
            if (busy16) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        total++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 20'h00000) begin
            bad++;
            $display("[TB] FAIL reset16: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy16, done16, sum16, cout16, ovf16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One isolated 8-bit operation: latency, busy length, result, pulse width.
    task automatic test_single_op8(input string name, input logic [7:0] av,
                                   input logic [7:0] bv, input logic s,
                                   input logic c);
        int   bc;
        int   lat;
        bit   seen;
        exp_t e;
        drive_start8(av, bv, s, c);
        @(negedge clk);
        start8 = 1'b0;
        scramble8();
        wait_done8(bc, lat, seen);
        total++;
        if (!seen || bc != 8 || lat != 8) begin
            bad++;
            $display("[TB] FAIL %s timing: got done=%b busy_cycles=%0d latency=%0d, want done=1 8 8",
                     name, seen, bc, lat);
        end
        if (exp8_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL %s scoreboard: got empty queue, want one entry", name);
        end else begin
            e = exp8_q.pop_front();
            total++;
            if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
                bad++;
                $display("[TB] FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         name, sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
            end
        end
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s busy_in_done: got %b want 0", name, busy8);
        end
        @(negedge clk);
        total++;
        if (done8 !== 1'b0 || sum8 !== e.sum[7:0]) begin
            bad++;
            $display("[TB] FAIL %s after_done: got done=%b sum=%h, want done=0 sum=%h",
                     name, done8, sum8, e.sum[7:0]);
        end
    endtask

    task automatic test_single_op16(input string name, input logic [15:0] av,
                                    input logic [15:0] bv, input logic s,
                                    input logic c);
        int   bc;
        int   lat;
        bit   seen;
        exp_t e;
        drive_start16(av, bv, s, c);
        @(negedge clk);
        start16 = 1'b0;
        scramble16();
        wait_done16(bc, lat, seen);
        total++;
        if (!seen || bc != 4 || lat != 4) begin
            bad++;
            $display("[TB] FAIL %s timing: got done=%b busy_cycles=%0d latency=%0d, want done=1 4 4",
                     name, seen, bc, lat);
        end
        if (exp16_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL %s scoreboard: got empty queue, want one entry", name);
        end else begin
            e = exp16_q.pop_front();
            total++;
            if ({sum16, cout16, ovf16} !== {e.sum, e.cout, e.ovf}) begin
                bad++;
                $display("[TB] FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         name, sum16, cout16, ovf16, e.sum, e.cout, e.ovf);
            end
        end
        @(negedge clk);
        total++;
        if (done16 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s after_done: got done=%b want 0", name, done16);
        end
    endtask

    // A start pulse during RUN must be ignored without disturbing the result.
    task automatic test_ignore_start();
        int   bc;
        int   bc2;
        int   lat;
        bit   seen;
        exp_t e;
        drive_start8(8'h3C, 8'h0F, 1'b0, 1'b1);
        bc = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (busy8) bc++;
            start8 = (i == 3);
            if (i == 3) begin
                a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b0;
            end else begin
                scramble8();
            end
        end
        @(negedge clk);
        wait_done8(bc2, lat, seen);
        total++;
        if (!seen || (bc + bc2) != 8 || lat != 4) begin
            bad++;
            $display("[TB] FAIL ignore_start timing: got done=%b busy_cycles=%0d, want done=1 8",
                     seen, bc + bc2);
        end
        e = exp8_q.pop_front();
        total++;
        if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
            bad++;
            $display("[TB] FAIL ignore_start result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL ignore_start extra_op: got a second operation, want none");
        end
    endtask

    // start held high through the done cycle launches the next operation.
    task automatic test_back_to_back();
        int   bc;
        int   lat;
        bit   seen;
        exp_t e;
        drive_start8(8'hC8, 8'h64, 1'b0, 1'b0);
        @(negedge clk);
        drive_start8(8'h20, 8'h50, 1'b1, 1'b1);
        wait_done8(bc, lat, seen);
        total++;
        if (!seen || lat != 8) begin
            bad++;
            $display("[TB] FAIL b2b first_done: got done=%b latency=%0d, want done=1 8", seen, lat);
        end
        e = exp8_q.pop_front();
        total++;
        if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
            bad++;
            $display("[TB] FAIL b2b first_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
        start8 = 1'b0;
        scramble8();
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b restart: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
        end
        wait_done8(bc, lat, seen);
        total++;
        if (!seen || (lat + 1) != 9) begin
            bad++;
            $display("[TB] FAIL b2b spacing: got done=%b gap=%0d, want done=1 gap=9", seen, lat + 1);
        end
        e = exp8_q.pop_front();
        total++;
        if ({sum8, cout8, ovf8} !== {e.sum[7:0], e.cout, e.ovf}) begin
            bad++;
            $display("[TB] FAIL b2b second_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset in the third RUN cycle drops the operation at once.
    task automatic test_reset_mid_run();
        bit seen;
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL reset_mid no_done: got activity after reset, want none");
        end
        test_single_op8("after_reset", 8'h10, 8'h20, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] ra16;
        logic [15:0] rb16;
        total = 0;
        bad   = 0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        rst_n = 1'b0;

        test_reset();
        test_single_op8("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0);
        test_single_op8("add_overflow", 8'h7F, 8'h01, 1'b0, 1'b0);
        test_single_op8("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1);
        test_single_op8("sub_no_borrow", 8'h80, 8'h01, 1'b1, 1'b0);
        test_single_op16("digit4_add", 16'h1234, 16'hEDCB, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            test_single_op8("random8", ra, rb, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            test_single_op16("random16", ra16, rb16, 1'($urandom), 1'($urandom));
        end
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor. Processes DIGIT bits per clock through a DIGIT-bit ripple slice, with a registered carry between digits. It is the sequential successor to the team's single-bit full adder: width, digit size and add/subtract mode are configurable, and a start/busy/done handshake is added. It is used wherever a narrow, low-area datapath trades latency for gates.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge.
- sub  input  1  0 = a + b + carry_in; 1 = a − b (carry_in ignored).
- a  input  WIDTH  operand A; sampled on the start edge only.
- b  input  WIDTH  operand B; sampled on the start edge only.
- carry_in  input  1  carry into bit 0 (add mode only).
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- carry_out  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- One clock. Reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start = 1.
  - RUN → DONE after STEPS digit cycles.
  - DONE → IDLE unconditionally, or DONE → RUN if start = 1 in that cycle.
- Accepted start:
  - a is loaded into shift register A.
  - In add mode, b is loaded into shift register B and the carry register takes carry_in.
  - In sub mode, B takes ~b and the carry register takes 1.
  - The digit counter is cleared.
- Each RUN cycle:
  - The slice adds the low DIGIT bits of A and B plus the carry register.
  - The slice result shifts into the top of the sum register from the MSB side; A and B shift right by DIGIT.
  - The carry register takes the slice carry-out.
  - The counter increments.
- On the last RUN cycle (counter = STEPS−1):
  - carry_out takes the final slice carry-out.
  - overflow takes the slice carry into its top bit XOR the slice carry-out.
- start while busy = 1 is ignored; the operation in progress is unaffected.
- a, b, sub and carry_in may change freely after the start edge; the result is unaffected.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset, including mid-operation:
  - Everything returns to reset values and state goes to IDLE.
  - A partial result is discarded, not completed.
- Reset values: busy = 0, done = 0, sum = 0, carry_out = 0, overflow = 0, internal carry = 0, counter = 0.

## Timing
- Start accepted at edge k:
  - busy = 1 during cycles k+1 … k+STEPS.
  - done = 1 during cycle k+STEPS+1 only, with busy = 0.
- sum, carry_out and overflow are stable and valid from cycle k+STEPS+1 until the next accepted start.
- Back-to-back: start = 1 during the done cycle is accepted at that cycle's closing edge.
  - busy rises the next cycle.
  - Throughput is one result per STEPS+1 cycles.
- sum is not guaranteed meaningful while busy = 1. It is a partially shifted value.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package/header serial_adder_pkg holds:
  - FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2).
  - A clog2 helper for the counter width, clog2(STEPS), minimum 1 bit.
- Sub-module adder_slice:
  - Parameter DIGIT.
  - Purely combinational ripple of full-adder cells.
  - Outputs s[DIGIT], cout, and c_msb (carry into the top bit).
  - serial_adder instantiates it once.
- A parameter check at elaboration flags WIDTH % DIGIT ≠ 0.

## Test plan
- WIDTH=8, DIGIT=1, add, a=0xFF, b=0x01, carry_in=0 → busy high 8 cycles, then done pulse with sum=0x00, carry_out=1, overflow=0.
- WIDTH=8, DIGIT=1, add, a=0x7F, b=0x01, carry_in=0 → sum=0x80, carry_out=0, overflow=1.
- WIDTH=8, DIGIT=1, sub, a=0x05, b=0x07, carry_in=1 (must be ignored) → sum=0xFE, carry_out=0.
- WIDTH=16, DIGIT=4, add, a=0x1234, b=0xEDCB, carry_in=1 → busy high 4 cycles, then sum=0x0000, carry_out=1, overflow=0.
- WIDTH=8, DIGIT=1, robustness sequence:
  - start again with new operands mid-RUN → ignored; the first result is delivered unchanged.
  - start held high through the done cycle → second operation begins immediately; second done arrives 9 cycles after the first.
- WIDTH=8, DIGIT=1, rst_n pulled low asynchronously in the 3rd RUN cycle → busy, done, sum, carry_out and overflow all 0 at once; no done pulse follows. After rst_n rises, a fresh start with 0x10+0x20 → sum=0x30.
